apb_arb_requester: RTL and testbench

APB_ARB_REQUESTER -- requirements
Module: apb_arb_requester

---
 rtl/apb_arb_requester_if.sv | 54 +++++
 rtl/apb_arb_requester.sv | 180 ++++++++++++++++++
 tb/tb_apb_arb_requester.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_requester_if
// Description : Bundles the two-requester request/response handshake and the
//               APB bus of apb_arb_requester. The master modport is the
//               arbiter/APB-master view; the slave modport is the view of the
//               environment (requesters plus peripheral).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_arb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Requester side
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*STRB_WIDTH-1:0] req_strb;
  logic [5:0]              req_prot;
  logic [1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  // APB side
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [STRB_WIDTH-1:0]   pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_requester
// Description : Two-requester round-robin arbiter feeding a single APB master.
//               One transfer in flight; IDLE -> SETUP -> ACCESS sequencing.
//               Optional macro APB_ARB_TIMEOUT_EN aborts an ACCESS phase after
//               TIMEOUT_CYCLES cycles with pready low (error response).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic           pclk,
  input  wire logic           preset,
  apb_arb_requester_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  grant;
  logic                  winner_nxt;
  logic                  winner;
  logic                  last_grant;
  logic                  xfer_done;
  logic                  xfer_abort;

  logic                  xfer_write;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic [STRB_WIDTH-1:0] xfer_strb;
  logic [2:0]            xfer_prot;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic [2:0]            sel_prot;

  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt;

  // Count ACCESS cycles spent waiting on pready; restart for each transfer.
  always_ff @(posedge pclk) begin
    if (preset || state == SETUP) begin
      timeout_cnt <= '0;
    end else if (state == ACCESS && !bus.pready) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, arbitration and transfer completion decode.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    winner_nxt = winner;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          grant     = 1'b1;
          state_nxt = SETUP;
          // On a tie the requester that did not win last time goes next.
          if (bus.req_valid == 2'b11) begin
            winner_nxt = ~last_grant;
          end else begin
            winner_nxt = bus.req_valid[1];
          end
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          xfer_done = 1'b1;
          state_nxt = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          xfer_abort = 1'b1;
          state_nxt  = IDLE;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the candidate winner's request fields.
  always_comb begin
    sel_write = bus.req_write[winner_nxt];
    sel_prot  = winner_nxt ? bus.req_prot[5:3] : bus.req_prot[2:0];
    sel_addr  = winner_nxt ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : bus.req_addr[ADDR_WIDTH-1:0];
    sel_wdata = winner_nxt ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : bus.req_wdata[DATA_WIDTH-1:0];
    sel_strb  = winner_nxt ? bus.req_strb[2*STRB_WIDTH-1:STRB_WIDTH]
                           : bus.req_strb[STRB_WIDTH-1:0];
  end

  // Latch the granted request and generate the completion response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      winner     <= 1'b0;
      last_grant <= 1'b1;
      xfer_write <= 1'b0;
      xfer_addr  <= '0;
      xfer_wdata <= '0;
      xfer_strb  <= '0;
      xfer_prot  <= '0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 2'b00;
      if (grant) begin
        winner     <= winner_nxt;
        last_grant <= winner_nxt;
        xfer_write <= sel_write;
        xfer_addr  <= sel_addr;
        // Reads present zero write data and strobes on the bus.
        xfer_wdata <= sel_write ? sel_wdata : '0;
        xfer_strb  <= sel_write ? sel_strb : '0;
        xfer_prot  <= sel_prot;
      end
      if (xfer_done) begin
        resp_valid <= winner ? 2'b10 : 2'b01;
        resp_rdata <= xfer_write ? '0 : bus.prdata;
        resp_err   <= bus.pslverr;
      end else if (xfer_abort) begin
        resp_valid <= winner ? 2'b10 : 2'b01;
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = grant ? (winner_nxt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.psel       = (state != IDLE);
  assign bus.penable    = (state == ACCESS);
  assign bus.pwrite     = xfer_write;
  assign bus.paddr      = xfer_addr;
  assign bus.pwdata     = xfer_wdata;
  assign bus.pstrb      = xfer_strb;
  assign bus.pprot      = xfer_prot;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;
endmodule
`default_nettype wire

// File: tb/tb_apb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_arb_requester
// Description : Directed self-checking bench for apb_arb_requester (single
//               read, tie round-robin, wait states, slave error, timeout or
//               stall, reset mid-transfer). Honours APB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arb_requester;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk = 1'b0;
  logic preset;
  int   total = 0;
  int   bad   = 0;

  apb_arb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_arb_requester #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus.master)
  );

  always #5 pclk = ~pclk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    preset        = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_pstrb", bus.pstrb, 0);
    check("rst_pprot", bus.pprot, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    preset = 1'b0;
    tick();
    check("idle_no_ready", bus.req_ready, 0);

    // Single read from requester 0
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0000_0999, 32'h0000_0010};
    bus.req_prot  = 6'b000_010;
    #1;
    check("rd_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    check("rd_setup_psel", bus.psel, 1);
    check("rd_setup_penable", bus.penable, 0);
    check("rd_setup_paddr", bus.paddr, 32'h10);
    check("rd_setup_pwrite", bus.pwrite, 0);
    check("rd_setup_pprot", bus.pprot, 3'b010);
    check("rd_setup_pstrb", bus.pstrb, 0);
    check("rd_setup_ready_drop", bus.req_ready, 0);
    bus.pready = 1'b1;
    bus.prdata = 32'hA5A5_A5A5;
    tick();
    check("rd_access_penable", bus.penable, 1);
    check("rd_access_resp_none", bus.resp_valid, 0);
    tick();
    bus.pready = 1'b0;
    check("rd_resp_valid", bus.resp_valid, 2'b01);
    check("rd_resp_rdata", bus.resp_rdata, 32'hA5A5_A5A5);
    check("rd_resp_err", bus.resp_err, 0);
    check("rd_idle_psel", bus.psel, 0);
    tick();
    check("rd_resp_one_shot", bus.resp_valid, 0);

    // Tie: fresh reset so requester 0 wins first, then alternate
    preset = 1'b1;
    tick();
    preset = 1'b0;
    bus.req_addr  = {32'h0000_0200, 32'h0000_0100};
    bus.req_valid = 2'b11;
    bus.pready    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  exp_ready;
      logic [31:0] exp_addr;
      exp_ready = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr  = (k % 2 == 1) ? 32'h200 : 32'h100;
      #1;
      check("tie_grant", bus.req_ready, exp_ready);
      tick();
      check("tie_ready_single", bus.req_ready, 0);
      check("tie_setup", {bus.psel, bus.penable}, 2'b10);
      check("tie_paddr", bus.paddr, exp_addr);
      bus.prdata = 32'h1111_0000 + k;
      tick();
      check("tie_access", {bus.psel, bus.penable}, 2'b11);
      tick();
      check("tie_resp_valid", bus.resp_valid, exp_ready);
      check("tie_resp_rdata", bus.resp_rdata, 32'h1111_0000 + k);
      check("tie_idle_gap", bus.psel, 0);
    end
    bus.req_valid = 2'b00;
    bus.pready    = 1'b0;
    tick();

    // Write with three wait states from requester 1
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr  = {32'h0000_0044, 32'h0};
    bus.req_wdata = {32'hDEAD_BEEF, 32'h0};
    bus.req_strb  = 8'b0110_0000;
    bus.req_prot  = 6'b101_000;
    #1;
    check("wr_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    check("wr_setup", {bus.psel, bus.penable}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_access", {bus.psel, bus.penable}, 2'b11);
      check("wr_pwrite", bus.pwrite, 1);
      check("wr_paddr", bus.paddr, 32'h44);
      check("wr_pwdata", bus.pwdata, 32'hDEAD_BEEF);
      check("wr_pstrb", bus.pstrb, 4'b0110);
      check("wr_pprot", bus.pprot, 3'b101);
      check("wr_no_resp", bus.resp_valid, 0);
      if (i == 3) bus.pready = 1'b1;
    end
    tick();
    bus.pready = 1'b0;
    check("wr_resp_valid", bus.resp_valid, 2'b10);
    check("wr_resp_err", bus.resp_err, 0);
    check("wr_resp_rdata", bus.resp_rdata, 0);
    tick();
    check("wr_resp_one_shot", bus.resp_valid, 0);

    // Slave error on a read from requester 0
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0, 32'h0000_0080};
    tick();
    bus.req_valid = 2'b00;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'h0BAD_0BAD;
    tick();
    tick();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check("err_resp_valid", bus.resp_valid, 2'b01);
    check("err_resp_err", bus.resp_err, 1);
    check("err_resp_rdata", bus.resp_rdata, 32'h0BAD_0BAD);
    tick();

    // Stuck pready from requester 1
    bus.req_valid = 2'b10;
    bus.req_write = 2'b00;
    tick();
    bus.req_valid = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      check("to_access", {bus.psel, bus.penable}, 2'b11);
      check("to_no_resp", bus.resp_valid, 0);
    end
    tick();
    check("to_abort_psel", bus.psel, 0);
    check("to_resp_valid", bus.resp_valid, 2'b10);
    check("to_resp_err", bus.resp_err, 1);
    check("to_resp_rdata", bus.resp_rdata, 0);
    // Start another transfer to be interrupted by reset
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("rstmid_in_access", {bus.psel, bus.penable}, 2'b11);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_access", {bus.psel, bus.penable}, 2'b11);
      check("stall_no_resp", bus.resp_valid, 0);
    end
`endif

    // Reset during ACCESS while the peripheral signals ready
    preset     = 1'b1;
    bus.pready = 1'b1;
    tick();
    check("rstmid_psel", bus.psel, 0);
    check("rstmid_penable", bus.penable, 0);
    check("rstmid_pwrite", bus.pwrite, 0);
    check("rstmid_paddr", bus.paddr, 0);
    check("rstmid_pprot", bus.pprot, 0);
    check("rstmid_resp_valid", bus.resp_valid, 0);
    check("rstmid_resp_rdata", bus.resp_rdata, 0);
    check("rstmid_resp_err", bus.resp_err, 0);
    preset     = 1'b0;
    bus.pready = 1'b0;
    tick();
    check("rstmid_after_resp", bus.resp_valid, 0);
    check("rstmid_after_psel", bus.psel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
